// File: rtl/counter_pkg.sv
// Shared constants for the counter / compare / PWM timer slice.
//   WIDTH : default counter width (must match the upstream up-counter)
//   MAX   : terminal count, all ones
//   ZERO  : all-zero count value
package counter_pkg;
    localparam int WIDTH = 8;
    localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO = '0;
endpackage

// File: rtl/count_event_detect.sv
// Raw event detector for the free-running up-counter.
// Remembers the previous count and flags a compare match or a MAX->0 wrap.
// Strobes are combinational; the parent registers them.
//   clk, reset : clock and synchronous active-high reset
//   count      : current upstream count
//   cmp_value  : compare value in use
//   match_evt  : count reached cmp_value on a new count value
//   wrap_evt   : count went from MAX to 0
module count_event_detect #(
    parameter int WIDTH = counter_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] cmp_value,
    output logic             match_evt,
    output logic             wrap_evt
);
    import counter_pkg::*;

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    logic [WIDTH-1:0] count_q_reg;
    logic             prev_valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q_reg    <= CNT_ZERO;
            prev_valid_reg <= 1'b0;
        end else begin
            count_q_reg    <= count;
            prev_valid_reg <= 1'b1;
        end
    end

    // A match needs the count to have moved, so a stalled counter sitting on
    // the compare value produces only one event.
    assign match_evt = prev_valid_reg && (count == cmp_value) && (count != count_q_reg);
    assign wrap_evt  = prev_valid_reg && (count_q_reg == CNT_MAX) && (count == CNT_ZERO);
endmodule

// File: rtl/counter_compare_pwm.sv
// Compare/PWM stage fed by the free-running up-counter.
// Double-buffered compare register, registered PWM, one-cycle match and wrap
// pulses, sticky flags with acknowledge, and a combined irq.
//   clk, reset  : clock and synchronous active-high reset
//   count       : upstream counter value
//   pwm_en      : 1 = run; 0 = idle (pwm low, compare writes go straight to active)
//   wr_en       : one-cycle compare write strobe, data on wr_data
//   irq_ack     : clears both sticky flags (a same-cycle event wins)
//   pwm         : registered PWM, high while count < cmp_active
//   match_pulse : one-cycle pulse per match event
//   wrap_pulse  : one-cycle pulse per MAX->0 wrap
//   match_flag  : sticky match flag
//   wrap_flag   : sticky wrap flag
//   irq         : match_flag | wrap_flag
//   cmp_active  : compare value in use
//   cmp_pending : shadow holds a value waiting for the next wrap
module counter_compare_pwm #(
    parameter int WIDTH = counter_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic             pwm_en,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             irq_ack,
    output logic             pwm,
    output logic             match_pulse,
    output logic             wrap_pulse,
    output logic             match_flag,
    output logic             wrap_flag,
    output logic             irq,
    output logic [WIDTH-1:0] cmp_active,
    output logic             cmp_pending
);
    import counter_pkg::*;

    logic             match_evt;
    logic             wrap_evt;
    logic [WIDTH-1:0] cmp_shadow_reg;
    logic [WIDTH-1:0] cmp_active_reg;
    logic             cmp_pending_reg;
    logic             pwm_reg;
    logic             match_pulse_reg;
    logic             wrap_pulse_reg;
    logic             match_flag_reg;
    logic             wrap_flag_reg;

    count_event_detect #(.WIDTH(WIDTH)) u_detect (
        .clk       (clk),
        .reset     (reset),
        .count     (count),
        .cmp_value (cmp_active_reg),
        .match_evt (match_evt),
        .wrap_evt  (wrap_evt)
    );

    // Compare double buffer. When idle a write lands in both registers so the
    // new value takes effect immediately. When running the write is parked in
    // the shadow and moved to active on the wrap; a write in the wrap cycle
    // itself transfers the old shadow and leaves the new value pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_shadow_reg  <= '0;
            cmp_active_reg  <= '0;
            cmp_pending_reg <= 1'b0;
        end else if (!pwm_en && wr_en) begin
            cmp_shadow_reg  <= wr_data;
            cmp_active_reg  <= wr_data;
            cmp_pending_reg <= 1'b0;
        end else begin
            if (wrap_evt) begin
                cmp_active_reg  <= cmp_shadow_reg;
                cmp_pending_reg <= 1'b0;
            end
            if (pwm_en && wr_en) begin
                cmp_shadow_reg  <= wr_data;
                cmp_pending_reg <= 1'b1;
            end
        end
    end

    // PWM, pulses and flags. A flag set in the same cycle as irq_ack wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_reg         <= 1'b0;
            match_pulse_reg <= 1'b0;
            wrap_pulse_reg  <= 1'b0;
            match_flag_reg  <= 1'b0;
            wrap_flag_reg   <= 1'b0;
        end else begin
            pwm_reg         <= pwm_en && (count < cmp_active_reg);
            match_pulse_reg <= match_evt;
            wrap_pulse_reg  <= wrap_evt;
            match_flag_reg  <= match_evt || (match_flag_reg && !irq_ack);
            wrap_flag_reg   <= wrap_evt  || (wrap_flag_reg  && !irq_ack);
        end
    end

    assign pwm         = pwm_reg;
    assign match_pulse = match_pulse_reg;
    assign wrap_pulse  = wrap_pulse_reg;
    assign match_flag  = match_flag_reg;
    assign wrap_flag   = wrap_flag_reg;
    assign irq         = match_flag_reg | wrap_flag_reg;
    assign cmp_active  = cmp_active_reg;
    assign cmp_pending = cmp_pending_reg;
endmodule

// File: tb/tb_counter_compare_pwm.sv
module tb_counter_compare_pwm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] count = 8'd0;
    logic       pwm_en = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       irq_ack = 1'b0;
    logic       pwm, match_pulse, wrap_pulse, match_flag, wrap_flag, irq, cmp_pending;
    logic [7:0] cmp_active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_compare_pwm #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .count       (count),
        .pwm_en      (pwm_en),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .irq_ack     (irq_ack),
        .pwm         (pwm),
        .match_pulse (match_pulse),
        .wrap_pulse  (wrap_pulse),
        .match_flag  (match_flag),
        .wrap_flag   (wrap_flag),
        .irq         (irq),
        .cmp_active  (cmp_active),
        .cmp_pending (cmp_pending)
    );

    // Present a count, clock once, and settle 1 time unit past the edge.
    task automatic step(input logic [7:0] c);
        count = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(8'd0);
        step(8'd0);
        checks++;
        if ({pwm, match_pulse, wrap_pulse, match_flag, wrap_flag, irq, cmp_pending, cmp_active} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {pwm, match_pulse, wrap_pulse, match_flag, wrap_flag, irq, cmp_pending, cmp_active});
        end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_idle_sweep();
        int bad = 0;
        pwm_en = 1'b0;
        for (int c = 0; c < 256; c++) begin
            step(8'(c));
            if (pwm !== 1'b0 || match_pulse !== 1'b0 || wrap_pulse !== 1'b0 || irq !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_sweep_quiet: %0d cycles with active outputs, want 0", bad);
        end
        step(8'd0);
        checks++;
        if (wrap_pulse !== 1'b1 || wrap_flag !== 1'b1 || pwm !== 1'b0) begin
            errors++;
            $display("FAIL idle_wrap: wrap_pulse=%b wrap_flag=%b pwm=%b, want 1 1 0", wrap_pulse, wrap_flag, pwm);
        end
        // compare value is 0, so the fresh count 0 after the wrap is also a match
        checks++;
        if (match_pulse !== 1'b1) begin
            errors++;
            $display("FAIL idle_match_zero: match_pulse=%b, want 1", match_pulse);
        end
        irq_ack = 1'b1;
        step(8'd0);
        irq_ack = 1'b0;
        checks++;
        if (match_flag !== 1'b0 || wrap_flag !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL ack_clear: match_flag=%b wrap_flag=%b irq=%b, want 0 0 0", match_flag, wrap_flag, irq);
        end
        $display("test_idle_sweep done");
    endtask

    task automatic test_pwm_duty();
        int bad_pwm = 0;
        int n_match = 0;
        int match_at = -1;
        pwm_en = 1'b0;
        wr_en = 1'b1; wr_data = 8'd64;
        step(8'd0);
        wr_en = 1'b0;
        checks++;
        if (cmp_active !== 8'd64 || cmp_pending !== 1'b0) begin
            errors++;
            $display("FAIL idle_write: cmp_active=%0d pending=%b, want 64 0", cmp_active, cmp_pending);
        end
        pwm_en = 1'b1;
        for (int c = 0; c < 256; c++) begin
            step(8'(c));
            if (pwm !== (c < 64)) bad_pwm++;
            if (match_pulse === 1'b1) begin n_match++; match_at = c; end
        end
        checks++;
        if (bad_pwm != 0) begin
            errors++;
            $display("FAIL pwm_duty64: %0d wrong pwm cycles, want 0", bad_pwm);
        end
        checks++;
        if (n_match != 1 || match_at != 64) begin
            errors++;
            $display("FAIL match_once: %0d pulses last after count %0d, want 1 after 64", n_match, match_at);
        end
        $display("test_pwm_duty done");
    endtask

    task automatic test_shadow();
        int bad = 0;
        step(8'd0);
        checks++;
        if (wrap_pulse !== 1'b1 || cmp_active !== 8'd64) begin
            errors++;
            $display("FAIL wrap_keep64: wrap_pulse=%b cmp_active=%0d, want 1 64", wrap_pulse, cmp_active);
        end
        for (int c = 1; c < 256; c++) begin
            wr_en = (c == 10); wr_data = 8'd128;
            step(8'(c));
            if (c >= 10 && (cmp_pending !== 1'b1 || cmp_active !== 8'd64)) bad++;
        end
        wr_en = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL shadow_hold: %0d cycles with active!=64 or pending!=1, want 0", bad);
        end
        step(8'd0);
        checks++;
        if (wrap_pulse !== 1'b1 || cmp_active !== 8'd128 || cmp_pending !== 1'b0) begin
            errors++;
            $display("FAIL shadow_transfer: wrap=%b active=%0d pending=%b, want 1 128 0", wrap_pulse, cmp_active, cmp_pending);
        end
        $display("test_shadow done");
    endtask

    task automatic test_write_on_wrap();
        for (int c = 1; c < 256; c++) begin
            wr_en = (c == 5); wr_data = 8'd100;
            step(8'(c));
        end
        wr_en = 1'b1; wr_data = 8'd200;
        step(8'd0);
        wr_en = 1'b0;
        checks++;
        if (wrap_pulse !== 1'b1 || cmp_active !== 8'd100 || cmp_pending !== 1'b1) begin
            errors++;
            $display("FAIL write_wrap: wrap=%b active=%0d pending=%b, want 1 100 1", wrap_pulse, cmp_active, cmp_pending);
        end
        for (int c = 1; c < 256; c++) step(8'(c));
        step(8'd0);
        checks++;
        if (cmp_active !== 8'd200 || cmp_pending !== 1'b0) begin
            errors++;
            $display("FAIL write_wrap_next: active=%0d pending=%b, want 200 0", cmp_active, cmp_pending);
        end
        $display("test_write_on_wrap done");
    endtask

    task automatic test_stall();
        int n_match = 0;
        logic first_ok;
        pwm_en = 1'b0;
        wr_en = 1'b1; wr_data = 8'd64;
        step(8'd0);
        wr_en = 1'b0;
        pwm_en = 1'b1;
        for (int c = 60; c < 64; c++) step(8'(c));
        step(8'd64);
        first_ok = match_pulse;
        if (match_pulse === 1'b1) n_match++;
        for (int i = 0; i < 4; i++) begin
            step(8'd64);
            if (match_pulse === 1'b1) n_match++;
        end
        step(8'd65);
        if (match_pulse === 1'b1) n_match++;
        checks++;
        if (n_match != 1 || first_ok !== 1'b1) begin
            errors++;
            $display("FAIL stall_match: %0d pulses first=%b, want 1 1", n_match, first_ok);
        end
        $display("test_stall done");
    endtask

    task automatic test_ack_vs_wrap();
        pwm_en = 1'b0; irq_ack = 1'b1;
        wr_en = 1'b1; wr_data = 8'd200;
        step(8'd65);
        wr_en = 1'b0; irq_ack = 1'b0;
        checks++;
        if (match_flag !== 1'b0 || wrap_flag !== 1'b0 || cmp_active !== 8'd200) begin
            errors++;
            $display("FAIL ack_setup: match_flag=%b wrap_flag=%b active=%0d, want 0 0 200", match_flag, wrap_flag, cmp_active);
        end
        pwm_en = 1'b1;
        for (int c = 66; c < 256; c++) step(8'(c));
        checks++;
        if (match_flag !== 1'b1 || wrap_flag !== 1'b0 || irq !== 1'b1) begin
            errors++;
            $display("FAIL match_flag_set: match_flag=%b wrap_flag=%b irq=%b, want 1 0 1", match_flag, wrap_flag, irq);
        end
        irq_ack = 1'b1;
        step(8'd0);
        irq_ack = 1'b0;
        checks++;
        if (match_flag !== 1'b0 || wrap_flag !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL ack_vs_wrap: match_flag=%b wrap_flag=%b irq=%b, want 0 1 1", match_flag, wrap_flag, irq);
        end
        $display("test_ack_vs_wrap done");
    endtask

    task automatic test_mid_reset();
        for (int c = 1; c <= 100; c++) step(8'(c));
        reset = 1'b1;
        step(8'd255);
        checks++;
        if ({pwm, match_pulse, wrap_pulse, match_flag, wrap_flag, irq, cmp_pending, cmp_active} !== 15'd0) begin
            errors++;
            $display("FAIL mid_reset: got %b, want all zero",
                     {pwm, match_pulse, wrap_pulse, match_flag, wrap_flag, irq, cmp_pending, cmp_active});
        end
        reset = 1'b0;
        step(8'd0);
        checks++;
        if (wrap_pulse !== 1'b0 || match_pulse !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL first_after_reset: wrap=%b match=%b irq=%b, want 0 0 0", wrap_pulse, match_pulse, irq);
        end
        step(8'd1);
        checks++;
        if (pwm !== 1'b0 || match_pulse !== 1'b0 || wrap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_run: pwm=%b match=%b wrap=%b, want 0 0 0", pwm, match_pulse, wrap_pulse);
        end
        $display("test_mid_reset done");
    endtask

    initial begin
        #1;
        test_reset();
        test_idle_sweep();
        test_pwm_duty();
        test_shadow();
        test_write_on_wrap();
        test_stall();
        test_ack_vs_wrap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
